// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac
// Streaming Q16.16 dot-product neuron: accumulates LEN products a*b on top of
// a bias, then presents the pre-activation sum with its ReLU and ReLU
// derivative until the consumer takes it.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand beat present on a/b (and bias on the first beat)
//   in_ready   : block accepts a beat this cycle
//   a, b       : signed Q16.16 activation / weight
//   bias       : signed Q16.16 bias, sampled on the first beat of a vector
//   out_valid  : result held on sum/act/d
//   out_ready  : consumer takes the result
//   sum        : signed Q16.16 pre-activation (wrapping accumulation)
//   act        : ReLU(sum)
//   d          : 1 iff sum > 0
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic [31:0] act,
    output logic        d
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [DATA_W-1:0]   prod_p1_q;
    logic                       vld_p1_q;
    logic signed [DATA_W-1:0]   acc_q;
    logic                       fire;
    logic                       first_beat;
    logic                       last_beat;

    // Q16.16 x Q16.16 -> Q16.16 by keeping bits [47:16] of the full product.
    // Dropping the low bits of a two's-complement value floors toward -inf.
    function automatic logic signed [DATA_W-1:0] mul_q16_floor(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        logic signed [2*DATA_W-1:0] full;
        full = $signed({{DATA_W{x[DATA_W-1]}}, x}) * $signed({{DATA_W{y[DATA_W-1]}}, y});
        return full[DATA_W+15:16];
    endfunction

    // Handshake outputs are forced low during reset regardless of state.
    always_comb begin
        in_ready   = !rst && ((state_q == S_IDLE) || (state_q == S_ACC));
        out_valid  = !rst && (state_q == S_DONE);
        fire       = in_valid && in_ready;
        first_beat = fire && (state_q == S_IDLE);
        // cnt_q is 0 in IDLE, so LEN==1 makes the first beat also the last.
        last_beat  = fire && (cnt_q == LAST_CNT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ACC: begin
                if (fire) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_beat ? S_DRAIN : S_ACC;
                end
            end
            // The last product is still in the p1 register; one edge folds it in.
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vld_p1_q  <= 1'b0;
            prod_p1_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // p1: product of the beat transferred on this edge
            vld_p1_q <= fire;
            if (fire) begin
                prod_p1_q <= mul_q16_floor($signed(a), $signed(b));
            end
            // p2: accumulator; a first beat can never coincide with a pending
            // product because DRAIN/DONE separate consecutive vectors.
            if (first_beat) begin
                acc_q <= $signed(bias);
            end else if (vld_p1_q) begin
                acc_q <= acc_q + prod_p1_q;
            end
        end
    end

    always_comb begin
        sum = acc_q;
        d   = (acc_q > 32'sd0);
        act = d ? acc_q : '0;
    end

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, d;
    logic [31:0] a, b, bias, sum, act;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, d1;
    logic [31:0] a1, b1, bias1, sum1, act1;

    int errors = 0;
    int checks = 0;

    logic [31:0] va [LEN];
    logic [31:0] vb [LEN];
    logic [31:0] vbias;

    always #5 clk = ~clk;

    neuron_mac #(.LEN(LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .act(act), .d(d)
    );

    neuron_mac #(.LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bias(bias1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .act(act1), .d(d1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference: exact real-valued floor of each product, summed with the bias
    // in wide integer arithmetic, then reduced modulo 2^32.
    function automatic logic [31:0] ref_sum(input int n);
        longint acc;
        acc = longint'($signed(vbias));
        for (int i = 0; i < n; i++) begin
            acc += (longint'($signed(va[i])) * longint'($signed(vb[i]))) >>> 16;
        end
        return acc[31:0];
    endfunction

    function automatic logic [31:0] ref_act(input logic [31:0] s);
        return ($signed(s) > 0) ? s : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input bit bubbles, input int hold, input logic [31:0] exp_s);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < LEN && guard < 500) begin
            in_valid  = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            a         = va[sent];
            b         = vb[sent];
            bias      = (sent == 0) ? vbias : $urandom;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = $urandom;
        b         = $urandom;
        bias      = $urandom;
        chk("beats_accepted", 32'(sent), 32'(LEN));
        #1;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("sum", sum, exp_s);
        chk("act", act, ref_act(exp_s));
        chk("d", {31'd0, d}, {31'd0, ($signed(exp_s) > 0)});
        for (int k = 0; k < hold; k++) begin
            tick();
            in_valid = 1'($urandom_range(0, 1));
            #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum", sum, exp_s);
            chk("stall_act", act, ref_act(exp_s));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic send_len1(input logic [31:0] exp_s);
        in_valid1 = 1'b1;
        a1        = va[0];
        b1        = vb[0];
        bias1     = vbias;
        #1;
        chk("len1_in_ready", {31'd0, in_ready1}, 32'd1);
        tick();
        in_valid1 = 1'b0;
        #1;
        chk("len1_drain_out_valid", {31'd0, out_valid1}, 32'd0);
        tick();
        chk("len1_out_valid", {31'd0, out_valid1}, 32'd1);
        chk("len1_sum", sum1, exp_s);
        chk("len1_ref_sum", sum1, ref_sum(1));
        chk("len1_d", {31'd0, d1}, {31'd0, ($signed(exp_s) > 0)});
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        #1;
        chk("len1_release_in_ready", {31'd0, in_ready1}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bias = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; bias1 = '0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready1", {31'd0, in_ready1}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_sum", sum, 32'd0);
        chk("post_rst_act", act, 32'd0);
        chk("post_rst_d", {31'd0, d}, 32'd0);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1.0 * 2.0 four times, zero bias
        vbias = 32'h0;
        for (int i = 0; i < LEN; i++) begin va[i] = 32'h00010000; vb[i] = 32'h00020000; end
        send_and_check(1'b0, 0, 32'h00080000);

        // -1.0 * 2.0 four times plus 1.0 bias
        vbias = 32'h00010000;
        for (int i = 0; i < LEN; i++) begin va[i] = 32'hFFFF0000; vb[i] = 32'h00020000; end
        send_and_check(1'b0, 0, 32'hFFF90000);

        // accumulation wraps past the positive limit
        vbias = 32'h7FFF0000;
        for (int i = 0; i < LEN; i++) begin va[i] = 32'h00010000; vb[i] = 32'h00010000; end
        send_and_check(1'b0, 0, 32'h80030000);

        // random operands, bubbles, consumer stalls 5 cycles
        vbias = $urandom;
        for (int i = 0; i < LEN; i++) begin va[i] = $urandom; vb[i] = $urandom; end
        send_and_check(1'b1, 5, ref_sum(LEN));

        // reset after 2 of 4 beats discards the partial vector
        in_valid = 1'b1;
        a = 32'h00050000; b = 32'h00030000; bias = 32'h12340000;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("midrst_no_out_valid", {31'd0, out_valid}, 32'd0);
        end
        vbias = 32'h00000100;
        for (int i = 0; i < LEN; i++) begin va[i] = 32'h00008000; vb[i] = 32'h00040000; end
        send_and_check(1'b0, 0, 32'h00080100);

        // random vectors with random bubbles and stalls
        for (int v = 0; v < 8; v++) begin
            vbias = $urandom;
            for (int i = 0; i < LEN; i++) begin
                va[i] = (v % 2 == 0) ? $urandom : {{16{1'b0}}, 16'($urandom)} - 32'h00008000;
                vb[i] = $urandom;
            end
            send_and_check(1'($urandom_range(0, 1)), $urandom_range(0, 3), ref_sum(LEN));
        end

        // LEN=1: floor of -epsilon * 0.5 and of +epsilon * 0.5
        vbias = 32'h0;
        va[0] = 32'hFFFFFFFF; vb[0] = 32'h00008000;
        send_len1(32'hFFFFFFFF);
        va[0] = 32'h00000001; vb[0] = 32'h00008000;
        send_len1(32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning the number of (a,b) beats per dot product; legal range is 1..256.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand beat is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-006 SHALL have port a, input, 32 bits: signed Q16.16 activation.
REQ-007 SHALL have port b, input, 32 bits: signed Q16.16 weight.
REQ-008 SHALL have port bias, input, 32 bits: signed Q16.16 bias, sampled only on the first beat of a vector.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port sum, output, 32 bits: signed Q16.16 pre-activation.
REQ-012 SHALL have port act, output, 32 bits: ReLU of sum.
REQ-013 SHALL have port d, output, 1 bit: ReLU derivative, 1 iff sum > 0 (signed).

Function
REQ-014 SHALL transfer a beat on a rising edge iff in_valid && in_ready.
REQ-015 SHALL form each product as bits [47:16] of the 64-bit signed a*b: truncation toward minus infinity, no rounding, no saturation.
REQ-016 SHALL register each product (p_reg, p_vld) on the edge the beat transfers.
REQ-017 SHALL add p_reg into the 32-bit accumulator on the next edge; accumulation wraps two's-complement and never saturates.
REQ-018 SHALL load the accumulator with bias on the first-beat transfer edge, discarding any prior value.
REQ-019 SHALL implement states IDLE, ACC, DRAIN and DONE.
  - IDLE: no beats of the current vector accepted.
  - ACC: 1..LEN-1 beats accepted.
  - DRAIN: all LEN beats accepted, last product pending.
  - DONE: result held.
REQ-020 SHALL make these state transitions:
  - IDLE to ACC on the first beat, or IDLE to DRAIN if LEN==1.
  - ACC to DRAIN on the LEN-th beat.
  - DRAIN to DONE unconditionally on the next edge.
  - DONE to IDLE on an edge with out_ready==1.
REQ-021 SHALL drive in_ready=1 in IDLE and ACC, and 0 in DRAIN and DONE.
REQ-022 SHALL hold state when in_valid is low in IDLE or ACC; bubbles are allowed anywhere mid-vector.
REQ-023 SHALL track accepted beats with a counter that clears on leaving DONE and never exceeds LEN.
REQ-024 SHALL drive out_valid=1 exactly in DONE: it first rises in the second cycle after the last-beat transfer edge, i.e. the last beat is accepted at edge E and out_valid is high after edge E+1.
REQ-025 SHALL hold sum, act and d stable while out_valid=1 && out_ready==0.
REQ-026 SHALL derive act and d combinationally from the accumulator: act = sum > 0 ? sum : 0, and d = (sum > 0).
REQ-027 SHALL ignore out_ready outside DONE.
REQ-028 SHALL ignore bias on non-first beats.
REQ-029 SHALL give a full vector a minimum period of LEN+2 cycles when in_valid and out_ready are held high.

Reset
REQ-030 SHALL, on any edge with rst=1, set: state IDLE, accumulator 0, p_reg 0, p_vld 0, counter 0.
REQ-031 SHALL force in_ready=0 and out_valid=0 while rst=1.
REQ-032 SHALL, after rst deasserts, output sum=0, act=0, d=0, out_valid=0 and in_ready=1.
REQ-033 SHALL discard a partial vector or pending result when rst is asserted mid-operation; no out_valid follows.

Verification
REQ-034 SHALL pass this scenario: LEN=4, bias=0, four beats a=0x00010000, b=0x00020000, back-to-back -> sum=0x00080000, act=0x00080000, d=1, out_valid high 2 cycles after the last transfer cycle.
REQ-035 SHALL pass this scenario: bias=0x00010000, four beats a=0xFFFF0000, b=0x00020000 -> sum=0xFFF90000, act=0, d=0.
REQ-036 SHALL pass this scenario: a=0xFFFFFFFF, b=0x00008000, bias=0, LEN=1 -> sum=0xFFFFFFFF (floor); a=0x00000001, b=0x00008000 -> sum=0.
REQ-037 SHALL pass this scenario: bias=0x7FFF0000, four beats a=b=0x00010000 -> sum=0x80030000 (wrapped), act=0, d=0.
REQ-038 SHALL pass this scenario: in_valid random bubbles plus out_ready low for 5 cycles in DONE -> in_ready=0 and outputs stable throughout; one out_ready pulse returns to IDLE with in_ready=1 the next cycle.
REQ-039 SHALL pass this scenario: rst pulsed after 2 of 4 beats -> no out_valid; the next full vector gives its exact expected sum with no residue.
